// File: rtl/pixel_row_fifo.sv
// Row-in / pixel-out FIFO for the PPU pixel pipeline with flush, fine-scroll discard and
// underflow reporting. Define PIXEL_FIFO_MIX_EN to add the sprite-row merge port.
module pixel_row_fifo #(
  parameter int PIXEL_W    = 2,
  parameter int ROW_PIXELS = 8,
  parameter int DEPTH      = 16
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            tclk_in,
  input  logic                            flush_in,
  input  logic                            push_valid_in,
  input  logic [ROW_PIXELS*PIXEL_W-1:0]   push_pixels_in,
  output logic                            push_ready_out,
  input  logic                            pop_in,
  output logic [PIXEL_W-1:0]              pixel_out,
  output logic                            pixel_valid_out,
  input  logic                            discard_load_in,
  input  logic [2:0]                      discard_cnt_in,
  output logic                            discarding_out,
  output logic [$clog2(DEPTH+1)-1:0]      occupancy_out,
  output logic                            empty_out,
  output logic                            underflow_out
`ifdef PIXEL_FIFO_MIX_EN
  ,
  input  logic                            mix_valid_in,
  input  logic [ROW_PIXELS*PIXEL_W-1:0]   mix_pixels_in,
  output logic                            mix_err_out
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  typedef enum logic {ST_STREAM = 1'b0, ST_DISCARD = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]        occ_q, occ_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [PIXEL_W-1:0]   pixel_q, pixel_d;
  logic                 pixel_valid_q, pixel_valid_d;
  logic                 underflow_q, underflow_d;
  logic [PIXEL_W-1:0]   mem_q [DEPTH];
  logic [PIXEL_W-1:0]   mem_m [DEPTH];
  logic [PIXEL_W-1:0]   mem_d [DEPTH];
  logic                 empty;
  logic                 push_fire, load_fire, pop_fire, drop_fire;
`ifdef PIXEL_FIFO_MIX_EN
  logic                 mix_err_q, mix_err_d;
  logic [PIXEL_W-1:0]   mix_px;
  logic [PW-1:0]        mix_idx;
`endif

  assign empty          = (occ_q == '0);
  assign empty_out      = empty;
  assign occupancy_out  = occ_q;
  assign push_ready_out = (occ_q <= OW'(DEPTH - ROW_PIXELS));
  assign discarding_out = (cnt_q != 3'd0);
  assign pixel_out      = pixel_q;
  assign pixel_valid_out = pixel_valid_q;
  assign underflow_out  = underflow_q;
`ifdef PIXEL_FIFO_MIX_EN
  assign mix_err_out    = mix_err_q;
`endif

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    cnt_d         = cnt_q;
    pixel_d       = pixel_q;
    pixel_valid_d = 1'b0;
    underflow_d   = 1'b0;
    mem_m         = mem_q;
    push_fire     = tclk_in & push_valid_in & push_ready_out;
    load_fire     = tclk_in & discard_load_in & (discard_cnt_in != 3'd0);
    pop_fire      = 1'b0;
    drop_fire     = 1'b0;
`ifdef PIXEL_FIFO_MIX_EN
    mix_err_d     = 1'b0;
    mix_px        = '0;
    mix_idx       = '0;
    // Merge lands on the head row before any pop so the popped pixel is the merged one.
    if (tclk_in && mix_valid_in) begin
      if (occ_q >= OW'(ROW_PIXELS)) begin
        for (int i = 0; i < ROW_PIXELS; i++) begin
          mix_idx = rd_ptr_q + PW'(i);
          mix_px  = mix_pixels_in[i*PIXEL_W +: PIXEL_W];
          if (mem_q[mix_idx][1:0] == 2'd0 && mix_px[1:0] != 2'd0)
            mem_m[mix_idx] = mix_px;
        end
      end else begin
        mix_err_d = 1'b1;
      end
    end
`endif
    if (state_q == ST_STREAM) begin
      pop_fire    = tclk_in & pop_in & ~empty;
      underflow_d = tclk_in & pop_in & empty;
    end else begin
      drop_fire   = tclk_in & ~load_fire & ~empty;
    end

    if (pop_fire) begin
      pixel_d       = mem_m[rd_ptr_q];
      pixel_valid_d = 1'b1;
    end
    if (pop_fire || drop_fire)
      rd_ptr_d = rd_ptr_q + PW'(1);

    if (load_fire) begin
      cnt_d   = discard_cnt_in;
      state_d = ST_DISCARD;
    end else if (drop_fire) begin
      cnt_d = cnt_q - 3'd1;
      if (cnt_q == 3'd1)
        state_d = ST_STREAM;
    end

    mem_d = mem_m;
    if (push_fire) begin
      for (int i = 0; i < ROW_PIXELS; i++)
        mem_d[wr_ptr_q + PW'(i)] = push_pixels_in[i*PIXEL_W +: PIXEL_W];
      wr_ptr_d = wr_ptr_q + PW'(ROW_PIXELS);
    end

    occ_d = occ_q + (push_fire ? OW'(ROW_PIXELS) : '0) - OW'(pop_fire | drop_fire);

    // Flush overrides every other same-edge action, including storage writes.
    if (flush_in) begin
      state_d       = ST_STREAM;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      occ_d         = '0;
      cnt_d         = 3'd0;
      pixel_valid_d = 1'b0;
      underflow_d   = 1'b0;
      mem_d         = mem_q;
`ifdef PIXEL_FIFO_MIX_EN
      mix_err_d     = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= ST_STREAM;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      cnt_q         <= 3'd0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
      underflow_q   <= 1'b0;
`ifdef PIXEL_FIFO_MIX_EN
      mix_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      cnt_q         <= cnt_d;
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
      underflow_q   <= underflow_d;
`ifdef PIXEL_FIFO_MIX_EN
      mix_err_q     <= mix_err_d;
`endif
    end
  end

  // Pixel storage is data only and carries no reset.
  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

endmodule
